// File: rtl/rv_multicycle_sequencer.sv
// Multi-cycle FETCH/WAIT/DECODE/EXEC/WB sequencer for the reduced addi/bne datapath.
// Optional macro ILLEGAL_TRAP_EN: illegal opcodes trap instead of retiring as a NOP.
module rv_multicycle_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req,
    input  logic                  imem_ack,
    input  logic [DATA_WIDTH-1:0] instr,
    input  logic                  eq,
    input  logic                  halt_req,
    output logic [DATA_WIDTH-1:0] ir,
    output logic                  pc_en,
    output logic                  pc_src,
    output logic                  reg_write,
    output logic                  alu_src,
    output logic [2:0]            alu_ctrl,
    output logic                  imm_src,
    output logic [2:0]            state,
    output logic [CNT_WIDTH-1:0]  instret,
    output logic                  trap
);

    localparam logic [6:0] OP_ADDI   = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [2:0] F3_BNE    = 3'b001;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_WAIT   = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] ir_q;
    logic [CNT_WIDTH-1:0]  instret_q;

    logic       is_addi, is_bne, ir_load;
    logic       req_c, pc_en_c, pc_src_c, rw_c;
    logic       alu_src_c, imm_src_c;
    logic [2:0] alu_ctrl_c;

    assign is_addi = (ir_q[6:0] == OP_ADDI);
    assign is_bne  = (ir_q[6:0] == OP_BRANCH) && (ir_q[14:12] == F3_BNE);

    always_comb begin
        state_d    = state_q;
        req_c      = 1'b0;
        ir_load    = 1'b0;
        pc_en_c    = 1'b0;
        pc_src_c   = 1'b0;
        rw_c       = 1'b0;
        alu_src_c  = 1'b0;
        alu_ctrl_c = 3'b000;
        imm_src_c  = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                if (halt_req) begin
                    state_d = S_HALT;
                end else begin
                    req_c = 1'b1;
                    if (imem_ack) begin
                        ir_load = 1'b1;
                        state_d = S_DECODE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                req_c = 1'b1;
                if (imem_ack) begin
                    ir_load = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_addi || is_bne) begin
                    state_d = S_EXEC;
                end else begin
`ifdef ILLEGAL_TRAP_EN
                    state_d = S_TRAP;
`else
                    state_d = S_WB;
`endif
                end
            end
            S_EXEC: begin
                if (is_bne) begin
                    alu_ctrl_c = 3'b001;
                    imm_src_c  = 1'b1;
                    pc_en_c    = 1'b1;
                    pc_src_c   = ~eq;
                    state_d    = S_FETCH;
                end else begin
                    alu_src_c = 1'b1;
                    state_d   = S_WB;
                end
            end
            S_WB: begin
                // Illegal-as-NOP also retires here, but without steering or write
                pc_en_c = 1'b1;
                if (is_addi) begin
                    alu_src_c = 1'b1;
                    rw_c      = (ir_q[11:7] != 5'd0);
                end
                state_d = S_FETCH;
            end
            S_HALT: begin
                if (!halt_req) state_d = S_FETCH;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_FETCH;
            ir_q      <= '0;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            if (ir_load) ir_q <= instr;
            if (pc_en_c) instret_q <= instret_q + CNT_WIDTH'(1);
        end
    end

    // Combinational outputs are gated so reset silences them without a clock edge
    assign imem_req  = rst & req_c;
    assign pc_en     = rst & pc_en_c;
    assign pc_src    = rst & pc_src_c;
    assign reg_write = rst & rw_c;
    assign alu_src   = rst & alu_src_c;
    assign imm_src   = rst & imm_src_c;
    assign alu_ctrl  = rst ? alu_ctrl_c : 3'b000;
    assign state     = state_q;
    assign ir        = ir_q;
    assign instret   = instret_q;

`ifdef ILLEGAL_TRAP_EN
    assign trap = rst && (state_q == S_TRAP);
`else
    assign trap = 1'b0;
`endif

endmodule

// File: tb/tb_rv_multicycle_sequencer.sv
// Scoreboard bench for rv_multicycle_sequencer: retire records queued at
// fetch time are popped and compared on every pc_en strobe.
module tb_rv_multicycle_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req, imem_ack;
    logic [31:0] instr, ir;
    logic        eq, halt_req;
    logic        pc_en, pc_src, reg_write, alu_src, imm_src, trap;
    logic [2:0]  alu_ctrl, state;
    logic [31:0] instret;

    typedef struct {
        logic        pc_src;
        logic        reg_write;
        logic        alu_src;
        logic [2:0]  alu_ctrl;
        logic        imm_src;
        logic [31:0] instret;
        logic [31:0] ir;
    } exp_t;

    exp_t        sb[$];
    int          n_run = 0;
    int          n_fail = 0;
    logic [31:0] exp_instret = 0;

    localparam logic [31:0] ADDI_X10 = 32'h0050_0513;
    localparam logic [31:0] BNE_M4   = 32'hFE05_1EE3;
    localparam logic [31:0] ADDI_X0  = 32'h0000_0013;
    localparam logic [31:0] ILLEGAL  = 32'h0000_007F;

    always #5 clk = ~clk;

    rv_multicycle_sequencer #(.DATA_WIDTH(32), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_ack(imem_ack),
        .instr(instr), .eq(eq), .halt_req(halt_req), .ir(ir),
        .pc_en(pc_en), .pc_src(pc_src), .reg_write(reg_write),
        .alu_src(alu_src), .alu_ctrl(alu_ctrl), .imm_src(imm_src),
        .state(state), .instret(instret), .trap(trap)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Retirement monitor
    always @(negedge clk) begin
        if (rst === 1'b1 && pc_en === 1'b1) begin
            check("pc_en_state", (state == 3'd3 || state == 3'd4), 1);
            if (sb.size() == 0) begin
                check("unexpected_pc_en", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("pc_src", pc_src, e.pc_src);
                check("reg_write", reg_write, e.reg_write);
                check("alu_src", alu_src, e.alu_src);
                check("alu_ctrl", alu_ctrl, e.alu_ctrl);
                check("imm_src", imm_src, e.imm_src);
                check("instret_pre", instret, e.instret);
                check("ir_retire", ir, e.ir);
            end
        end
    end

    // Caller is at posedge+1 with the DUT in FETCH
    task automatic run_instr(input logic [31:0] word, input int nwait,
                             input logic eqv);
        exp_t e;
        int   req_cnt = 0;
        int   cyc;
        int   exp_len;
        bit   done = 0;
        bit   is_addi = (word[6:0] == 7'b0010011);
        bit   is_bne = (word[6:0] == 7'b1100011) && (word[14:12] == 3'b001);
        e.ir = word;
        e.instret = exp_instret;
        e.pc_src = 0; e.reg_write = 0; e.alu_src = 0;
        e.alu_ctrl = 3'b000; e.imm_src = 0;
        if (is_addi) begin
            e.reg_write = (word[11:7] != 5'd0);
            e.alu_src = 1;
            exp_len = 4;
        end else if (is_bne) begin
            e.pc_src = ~eqv;
            e.alu_ctrl = 3'b001;
            e.imm_src = 1;
            exp_len = 3;
        end else begin
            exp_len = 3;
        end
        exp_len += nwait;
        sb.push_back(e);
        eq = eqv;
        halt_req = 0;
        imem_ack = (nwait == 0);
        instr = (nwait == 0) ? word : $urandom;
        @(negedge clk);
        req_cnt += int'(imem_req);
        check("fetch_state", state, 0);
        for (int k = 1; k <= nwait; k++) begin
            @(posedge clk); #1;
            imem_ack = (k == nwait);
            instr = (k == nwait) ? word : $urandom;
            @(negedge clk);
            req_cnt += int'(imem_req);
            check("wait_state", state, 1);
        end
        @(posedge clk); #1;
        imem_ack = 0;
        instr = $urandom;
        check("req_cycles", req_cnt, nwait + 1);
        @(negedge clk);
        check("decode_state", state, 2);
        check("decode_strobes", {imem_req, pc_en, reg_write}, 0);
        check("ir", ir, word);
        cyc = 2 + nwait;
        for (int i = 0; i < 12 && !done; i++) begin
            @(posedge clk); #1;
            if (state == 3'd0) done = 1;
            else cyc++;
        end
        check("latency", cyc, exp_len);
        check("imem_req_next", imem_req, 1);
        exp_instret++;
        check("instret", instret, exp_instret);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 0; imem_ack = 0; instr = 0; eq = 0; halt_req = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_state", state, 0);
        check("rst_req", imem_req, 0);
        check("rst_ir", ir, 0);
        check("rst_instret", instret, 0);
        check("rst_strobes", {pc_en, reg_write, trap}, 0);
        @(posedge clk); #1;
        rst = 1;

        run_instr(ADDI_X10, 0, 0);
        run_instr(BNE_M4, 0, 0);
        run_instr(BNE_M4, 0, 1);
        run_instr(ADDI_X0, 0, 0);
        run_instr(ADDI_X10, 3, 0);
        run_instr(BNE_M4, 2, 1);

        // halt at a fetch boundary
        halt_req = 1;
        @(negedge clk);
        check("halt_fetch_req", imem_req, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            imem_ack = 1;
            @(negedge clk);
            check("halt_state", state, 5);
            check("halt_strobes", {imem_req, pc_en, reg_write}, 0);
        end
        @(posedge clk); #1;
        imem_ack = 0;
        halt_req = 0;
        @(negedge clk);
        check("halt_exit_state", state, 5);
        @(posedge clk); #1;
        check("resume_state", state, 0);
        check("resume_req", imem_req, 1);
        run_instr(ADDI_X10, 1, 0);

        // asynchronous reset in the middle of bne EXEC
        eq = 0;
        imem_ack = 1;
        instr = BNE_M4;
        @(posedge clk); #1;
        imem_ack = 0;
        @(posedge clk); #1;
        check("pre_rst_exec", {state, pc_en}, {3'd3, 1'b1});
        #2 rst = 0;
        #1;
        check("arst_outputs",
              {imem_req, pc_en, pc_src, reg_write, alu_src, alu_ctrl,
               imm_src, state, trap}, 0);
        check("arst_ir", ir, 0);
        check("arst_instret", instret, 0);
        exp_instret = 0;
        @(posedge clk); #1;
        rst = 1;

        run_instr(ADDI_X10, 0, 0);

`ifdef ILLEGAL_TRAP_EN
        imem_ack = 1;
        instr = ILLEGAL;
        @(posedge clk); #1;
        imem_ack = 0;
        @(negedge clk);
        check("ill_decode", state, 2);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            imem_ack = i[0];
            @(negedge clk);
            check("trap_flag", trap, 1);
            check("trap_state", state, 6);
            check("trap_quiet", {imem_req, pc_en, reg_write}, 0);
            check("trap_instret", instret, exp_instret);
        end
`else
        run_instr(ILLEGAL, 1, 0);
        check("trap_tied", trap, 0);
`endif

        check("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/rv_multicycle_sequencer.md
Name: rv_multicycle_sequencer

Overview:
- Multi-cycle control sequencer for the reduced RISC-V datapath: PC, sign extender, register file and ALU.
- Replaces single-cycle decode with a state machine that fetches over a variable-latency req/ack instruction-memory handshake, latches the instruction, and steps decode, execute and writeback.
- Emits one-cycle PC-update and register-write strobes plus ALU/immediate steering.
- Supports addi (opcode 0010011) and bne (opcode 1100011, funct3 001); counts retired instructions.

Parameters:
- DATA_WIDTH, 32, instruction and IR width.
- CNT_WIDTH, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- imem_req  out  1  instruction fetch request; held until ack.
- imem_ack  in  1  fetch complete; instr valid this cycle.
- instr  in  DATA_WIDTH  fetched instruction word.
- eq  in  1  ALU equality flag (rs1 == rs2).
- halt_req  in  1  request stop at the next fetch boundary.
- ir  out  DATA_WIDTH  latched instruction register.
- pc_en  out  1  one-cycle PC update strobe.
- pc_src  out  1  0 = PC+4, 1 = PC+ImmOp; valid when pc_en = 1.
- reg_write  out  1  one-cycle register-file write strobe.
- alu_src  out  1  0 = rs2, 1 = ImmOp.
- alu_ctrl  out  3  000 = add, 001 = sub.
- imm_src  out  1  0 = I-type, 1 = B-type immediate.
- state  out  3  current state encoding, for debug.
- instret  out  CNT_WIDTH  retired-instruction count.
- trap  out  1  illegal-instruction flag (see Optional Feature).

Behaviour:
- Reset:
  - While rst = 0, all outputs are 0, ir = 0, instret = 0 and state = FETCH.
  - imem_req is forced to 0 while rst = 0, including reset asserted mid-instruction. A fetch in flight at reset is abandoned.
- State encodings: FETCH = 0, WAIT = 1, DECODE = 2, EXEC = 3, WB = 4, HALT = 5, TRAP = 6.
- FETCH:
  - If halt_req = 1: imem_req = 0, next state HALT.
  - Otherwise imem_req = 1. If imem_ack = 1 the same cycle: ir <= instr, next state DECODE. Else next state WAIT.
- WAIT:
  - imem_req = 1; halt_req is ignored.
  - On imem_ack = 1: ir <= instr, next state DECODE.
  - instr is sampled only on an ack cycle.
- DECODE:
  - Classify ir[6:0]: addi -> EXEC; bne -> EXEC; any other -> illegal (see Optional Feature).
  - All strobes are 0.
- EXEC:
  - addi: alu_src = 1, alu_ctrl = 000, imm_src = 0; next state WB.
  - bne: alu_src = 0, alu_ctrl = 001, imm_src = 1, pc_en = 1, pc_src = ~eq, instret += 1; next state FETCH.
- WB (addi only):
  - Steering held as in EXEC; pc_en = 1, pc_src = 0, instret += 1.
  - reg_write = 1 unless ir[11:7] = 0 (write to x0 suppressed); next state FETCH.
- HALT: all strobes 0; leaves for FETCH in the first cycle halt_req = 0.
- Steering outputs (alu_src, alu_ctrl, imm_src) are 0 outside EXEC/WB.
- Latency with zero-wait ack: addi 4 cycles and bne 3 cycles, FETCH to next FETCH. Each wait cycle adds 1.
- instret wraps modulo 2^CNT_WIDTH; at most one increment per instruction.
- pc_en and reg_write never assert in FETCH, WAIT, DECODE, HALT or TRAP.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined:
  - An illegal opcode in DECODE moves to TRAP and sets trap = 1.
  - TRAP is terminal until reset: no pc_en, no reg_write, imem_req = 0, instret frozen.
- Undefined:
  - An illegal opcode is a NOP: DECODE -> WB with reg_write = 0, pc_en = 1, pc_src = 0, instret += 1.
  - trap is tied to 0.

Test Plan:
1. addi x10,x0,5 (0x00500513), ack in the FETCH cycle -> DECODE, EXEC (alu_src = 1, alu_ctrl = 000), WB (reg_write = 1, pc_en = 1, pc_src = 0); instret 0 -> 1; next imem_req 4 cycles after the first.
2. bne x10,x0,-4 (0xFE051EE3) with eq = 0 -> EXEC pc_en = 1, pc_src = 1, alu_ctrl = 001, imm_src = 1, reg_write never 1; repeat with eq = 1 -> pc_src = 0; 3-cycle instruction.
3. addi x0,x0,0 (0x00000013) -> reg_write stays 0, pc_en pulses once, instret increments.
4. imem_ack delayed 3 cycles, instr toggling before ack -> imem_req high 4 consecutive cycles; ir equals instr from the ack cycle only.
5. halt_req = 1 entering FETCH -> imem_req = 0, state = 5, no strobes; drop halt_req -> FETCH the next cycle with imem_req = 1. Also: rst driven low mid-EXEC of bne -> all outputs 0 immediately (no clock edge), instret = 0.
6. Instruction 0x0000007F: with ILLEGAL_TRAP_EN -> trap = 1, state = 6, sticky across 10 cycles, instret unchanged. Without ILLEGAL_TRAP_EN -> NOP, pc_en pulse, instret += 1, trap = 0.
